// File: rtl/voter_pkg.sv
// Shared types and constants for the ballot collector and the one-hot voter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package voter_pkg;

    localparam int DEFAULT_BALLOT_W    = 3;
    localparam int DEFAULT_NUM_BALLOTS = 5;

    localparam logic [2:0] CAND_A = 3'b001;
    localparam logic [2:0] CAND_B = 3'b010;
    localparam logic [2:0] CAND_C = 3'b100;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/ballot_onehot_chk.sv
// Flags a ballot that has exactly one candidate bit set.
// Latency: combinational.
// Backpressure: none.
module ballot_onehot_chk #(
    parameter int W = 3
) (
    input  logic [W-1:0] ballot,
    output logic         is_onehot
);

    // x & (x-1) clears the lowest set bit; zero result with nonzero x means one bit
    assign is_onehot = (ballot != '0) && ((ballot & (ballot - 1'b1)) == '0);

endmodule

// File: rtl/ballot_collector.sv
// Collects one-hot ballots serially and presents a full round in parallel to the voter.
// Latency: out_valid rises the cycle after the last slot is filled.
// Backpressure: ballot_ready drops while a round is presented, until out_ack or abort.
module ballot_collector
    import voter_pkg::*;
#(
    parameter int NUM_BALLOTS = DEFAULT_NUM_BALLOTS,
    parameter int BALLOT_W    = DEFAULT_BALLOT_W,
    parameter int REJ_CNT_W   = 4,
    parameter int ROUND_CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BALLOT_W-1:0]             ballot_in,
    input  logic                            ballot_valid,
    output logic                            ballot_ready,
    input  logic                            abort,
    output logic [NUM_BALLOTS*BALLOT_W-1:0] ballots_out,
    output logic                            out_valid,
    input  logic                            out_ack,
    output logic                            bad_ballot,
    output logic [REJ_CNT_W-1:0]            reject_cnt,
    output logic [ROUND_CNT_W-1:0]          round_cnt
);

    localparam int IDX_W = (NUM_BALLOTS > 1) ? $clog2(NUM_BALLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLOTS - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [BALLOT_W-1:0] slot [NUM_BALLOTS];
    logic                is_onehot;
    logic                take;

    ballot_onehot_chk #(.W(BALLOT_W)) u_onehot_chk (
        .ballot    (ballot_in),
        .is_onehot (is_onehot)
    );

    assign take = ballot_valid && ballot_ready;

    // Slot 0 occupies the least significant field so it lines up with In_1.
    for (genvar i = 0; i < NUM_BALLOTS; i++) begin : g_out
        assign ballots_out[i*BALLOT_W +: BALLOT_W] = slot[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_COLLECT;
            idx          <= '0;
            out_valid    <= 1'b0;
            ballot_ready <= 1'b0;
            bad_ballot   <= 1'b0;
            reject_cnt   <= '0;
            round_cnt    <= '0;
            for (int i = 0; i < NUM_BALLOTS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            bad_ballot <= 1'b0;
            if (abort) begin
                // Discarding wins over both the ballot handshake and the ack.
                state        <= ST_COLLECT;
                idx          <= '0;
                out_valid    <= 1'b0;
                ballot_ready <= 1'b1;
                for (int i = 0; i < NUM_BALLOTS; i++) begin
                    slot[i] <= '0;
                end
            end else if (state == ST_COLLECT) begin
                ballot_ready <= 1'b1;
                if (take) begin
                    if (is_onehot) begin
                        slot[idx] <= ballot_in;
                        if (idx == LAST_IDX) begin
                            state        <= ST_PRESENT;
                            ballot_ready <= 1'b0;
                            out_valid    <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        bad_ballot <= 1'b1;
                        if (reject_cnt != '1) begin
                            reject_cnt <= reject_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                if (out_ack) begin
                    state        <= ST_COLLECT;
                    idx          <= '0;
                    out_valid    <= 1'b0;
                    ballot_ready <= 1'b1;
                    round_cnt    <= round_cnt + 1'b1;
                    for (int i = 0; i < NUM_BALLOTS; i++) begin
                        slot[i] <= '0;
                    end
                end
            end
        end
    end

endmodule
